// File: rtl/recon_icap_writer.sv
// recon_icap_writer
//   Consumes a bitstream returned by the DMA read engine as wide AXI-Stream
//   beats and writes it to ICAP one 32-bit word per cycle. One length command
//   is accepted per bitstream. The stream length is checked against the
//   command, and completion and error status are reported to the controller.
//
// Build option:
//   RECON_ICAP_BITSWAP_EN - when defined, each byte of icap_o is bit-reversed
//                           as the ICAPE3 primitive expects. When undefined,
//                           bytes pass unswapped. Word and byte order are the
//                           same in both builds.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_len/valid     bitstream byte length command; cmd_ready when idle
//   s_axis_*          bitstream beats; byte 0 is in tdata[7:0]
//   icap_avail        ICAP can take a write this cycle
//   icap_csib/rdwrb/o ICAP write interface (all registered)
//   status_done       one-cycle pulse at command end
//   status_error      bit0 short stream / bad length / missing keep, bit1 overrun
//   status_words      words written for the current/last command
module recon_icap_writer #(
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = 20,
  parameter int WORDS_PER_BEAT = DATA_WIDTH / 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  icap_avail,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  output logic [31:0]           icap_o,
  output logic                  status_done,
  output logic [1:0]            status_error,
  output logic [31:0]           status_words
);

  localparam int IDX_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int CNT_W = $clog2(WORDS_PER_BEAT + 1);
  localparam logic [LEN_WIDTH-1:0] BEAT_WORDS = LEN_WIDTH'(WORDS_PER_BEAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Converts a little-endian stream word into ICAP order: the earliest byte
  // lands in bits 31:24, optionally with each byte bit-reversed.
  function automatic logic [31:0] icap_order(input logic [31:0] w);
    logic [31:0] o;
    logic [31:0] r;
    o = {w[7:0], w[15:8], w[23:16], w[31:24]};
    r = o;
`ifdef RECON_ICAP_BITSWAP_EN
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*j + i] = o[8*j + 7 - i];
      end
    end
`endif
    return r;
  endfunction

  state_t                  state_r, state_s;
  logic [LEN_WIDTH-1:0]    remaining_r, remaining_s;
  logic                    buf_valid_r, buf_valid_s;
  logic [DATA_WIDTH-1:0]   buf_data_r, buf_data_s;
  logic [CNT_W-1:0]        buf_words_r, buf_words_s;
  logic                    buf_last_r, buf_last_s;   // beat carried tlast
  logic                    buf_final_r, buf_final_s; // beat exhausts remaining
  logic [IDX_W-1:0]        word_idx_r, word_idx_s;
  logic                    done_pend_r, done_pend_s;
  logic                    cmd_ready_r, cmd_ready_s;
  logic                    tready_r, tready_s;
  logic                    csib_r, csib_s;
  logic                    rdwrb_r, rdwrb_s;
  logic [31:0]             icap_data_r, icap_data_s;
  logic                    done_r, done_s;
  logic [1:0]              error_r, error_s;
  logic [31:0]             words_r, words_s;

  logic                    cmd_fire_s, beat_fire_s, emit_s, last_word_s, bad_len_s;
  logic                    keep_err_s, beat_final_s;
  logic [LEN_WIDTH-1:0]    rem_words_s;
  logic [CNT_W-1:0]        beat_words_s;
  logic [31:0]             cur_word_s;

  assign cmd_ready     = cmd_ready_r;
  assign s_axis_tready = tready_r;
  assign icap_csib     = csib_r;
  assign icap_rdwrb    = rdwrb_r;
  assign icap_o        = icap_data_r;
  assign status_done   = done_r;
  assign status_error  = error_r;
  assign status_words  = words_r;

  // Handshake strobes and the word currently selected from the beat buffer.
  always_comb begin
    cmd_fire_s  = cmd_valid & cmd_ready_r & (state_r == ST_IDLE);
    beat_fire_s = s_axis_tvalid & tready_r;
    emit_s      = (state_r == ST_STREAM) & buf_valid_r & icap_avail;
    last_word_s = ((CNT_W'(word_idx_r) + CNT_W'(1'b1)) == buf_words_r);
    bad_len_s   = (cmd_len == '0) || (cmd_len[1:0] != 2'b00);
    cur_word_s  = icap_order(buf_data_r[{word_idx_r, 5'b00000} +: 32]);
  end

  // Per-beat word count (clamped to what remains) and tkeep check on the
  // words that will actually be written.
  always_comb begin
    rem_words_s = remaining_r >> 2;
    if (rem_words_s >= BEAT_WORDS) begin
      beat_words_s = CNT_W'(WORDS_PER_BEAT);
      beat_final_s = (rem_words_s == BEAT_WORDS);
    end else begin
      beat_words_s = rem_words_s[CNT_W-1:0];
      beat_final_s = 1'b1;
    end
    keep_err_s = 1'b0;
    for (int k = 0; k < WORDS_PER_BEAT; k++) begin
      if ((CNT_W'(k) < beat_words_s) && (s_axis_tkeep[4*k +: 4] != 4'hF)) begin
        keep_err_s = 1'b1;
      end else begin
        keep_err_s = keep_err_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/STREAM/DRAIN controller.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    buf_valid_s = buf_valid_r;
    buf_data_s  = buf_data_r;
    buf_words_s = buf_words_r;
    buf_last_s  = buf_last_r;
    buf_final_s = buf_final_r;
    word_idx_s  = word_idx_r;
    done_pend_s = 1'b0;
    csib_s      = 1'b1;
    icap_data_s = icap_data_r;
    error_s     = error_r;
    words_s     = words_r;
    done_s      = done_pend_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          error_s     = 2'b00;
          words_s     = 32'd0;
          remaining_s = cmd_len;
          buf_valid_s = 1'b0;
          if (bad_len_s) begin
            error_s = 2'b01;
            done_s  = 1'b1;
          end else begin
            state_s = ST_STREAM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (beat_fire_s) begin
          buf_valid_s = 1'b1;
          buf_data_s  = s_axis_tdata;
          buf_words_s = beat_words_s;
          buf_last_s  = s_axis_tlast;
          buf_final_s = beat_final_s;
          word_idx_s  = '0;
          error_s[0]  = error_r[0] | keep_err_s | (s_axis_tlast & ~beat_final_s);
          error_s[1]  = error_r[1] | (~s_axis_tlast & beat_final_s);
        end else if (emit_s) begin
          csib_s      = 1'b0;
          icap_data_s = cur_word_s;
          words_s     = words_r + 32'd1;
          word_idx_s  = word_idx_r + IDX_W'(1'b1);
          if (remaining_r >= LEN_WIDTH'(3'd4)) begin
            remaining_s = remaining_r - LEN_WIDTH'(3'd4);
          end else begin
            remaining_s = '0;
          end
          if (last_word_s) begin
            buf_valid_s = 1'b0;
            if (buf_last_r) begin
              // Done is held back one cycle so it follows the final word.
              state_s     = ST_IDLE;
              done_pend_s = 1'b1;
            end else if (buf_final_r) begin
              state_s = ST_DRAIN;
            end else begin
              state_s = ST_STREAM;
            end
          end else begin
            buf_valid_s = 1'b1;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (beat_fire_s && s_axis_tlast) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        buf_valid_s = 1'b0;
      end
    endcase

    if (csib_s == 1'b0) begin
      rdwrb_s = 1'b0;
    end else if (state_s == ST_STREAM) begin
      rdwrb_s = 1'b0;
    end else begin
      rdwrb_s = 1'b1;
    end

    tready_s = ((state_s == ST_STREAM) && !buf_valid_s) || (state_s == ST_DRAIN);
    // Ready rises only after a full idle cycle so a pending done pulse is
    // never overlapped by the next command's status clear.
    cmd_ready_s = (state_s == ST_IDLE) && (state_r == ST_IDLE) && !cmd_fire_s;
  end

  // State, beat buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      buf_valid_r <= 1'b0;
      buf_data_r  <= '0;
      buf_words_r <= '0;
      buf_last_r  <= 1'b0;
      buf_final_r <= 1'b0;
      word_idx_r  <= '0;
      done_pend_r <= 1'b0;
      cmd_ready_r <= 1'b0;
      tready_r    <= 1'b0;
      csib_r      <= 1'b1;
      rdwrb_r     <= 1'b1;
      icap_data_r <= 32'd0;
      done_r      <= 1'b0;
      error_r     <= 2'b00;
      words_r     <= 32'd0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      buf_valid_r <= buf_valid_s;
      buf_data_r  <= buf_data_s;
      buf_words_r <= buf_words_s;
      buf_last_r  <= buf_last_s;
      buf_final_r <= buf_final_s;
      word_idx_r  <= word_idx_s;
      done_pend_r <= done_pend_s;
      cmd_ready_r <= cmd_ready_s;
      tready_r    <= tready_s;
      csib_r      <= csib_s;
      rdwrb_r     <= rdwrb_s;
      icap_data_r <= icap_data_s;
      done_r      <= done_s;
      error_r     <= error_s;
      words_r     <= words_s;
    end
  end

endmodule
